// File: rtl/commit_unit.sv
// ============================================================================
// Module   : commit_unit
// Purpose  : In-order retirement stage downstream of the ROB. Retires the ROB
//            head each cycle it is valid and ready, writes the register file,
//            releases map-table entries, performs stores over a req/ack
//            memory handshake, and stops retiring once a halt has retired.
// Ports    : clock/reset           - clock, synchronous active-high reset
//            head_*                - ROB head entry (valid/ready/flags/data)
//            mem_ack               - memory completed the outstanding store
//            commit                - head retires this cycle
//            rf_wr_*               - register-file write port
//            mt_clear_*            - map-table release port
//            mem_req/addr/data     - store request, held until ack
//            halted                - a halt instruction has retired
//            retired_count         - instructions retired since reset
//            store_count           - stores retired since reset
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_unit #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   head_valid,
    input  logic                   head_ready,
    input  logic                   head_wr_mem,
    input  logic                   head_halt,
    input  logic [4:0]             head_dest_reg,
    input  logic [XLEN-1:0]        head_value,
    input  logic [XLEN-1:0]        head_addr,
    input  logic [ROB_TAG_LEN-1:0] head_tag,
    input  logic                   mem_ack,
    output logic                   commit,
    output logic                   rf_wr_en,
    output logic [4:0]             rf_wr_idx,
    output logic [XLEN-1:0]        rf_wr_data,
    output logic                   mt_clear_en,
    output logic [4:0]             mt_clear_reg,
    output logic [ROB_TAG_LEN-1:0] mt_clear_tag,
    output logic                   mem_req,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_data,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired_count,
    output logic [CNT_WIDTH-1:0]   store_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [XLEN-1:0]        r_st_addr;
    logic [XLEN-1:0]        r_st_data;
    logic [CNT_WIDTH-1:0]   r_retired;
    logic [CNT_WIDTH-1:0]   r_stores;

    logic                   w_head_ok;
    logic                   w_latch;       // capture store address/data
    logic                   w_store_done;  // store acked and retiring

    assign w_head_ok = head_valid & head_ready;

    // ------------------------------------------------------------------
    // Next-state and output decode. Everything is forced to 0 while reset
    // is high so an in-flight store request drops in the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n    = r_state;
        w_latch      = 1'b0;
        w_store_done = 1'b0;
        commit       = 1'b0;
        rf_wr_en     = 1'b0;
        rf_wr_idx    = 5'd0;
        rf_wr_data   = '0;
        mt_clear_en  = 1'b0;
        mt_clear_reg = 5'd0;
        mt_clear_tag = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        mem_data     = '0;
        halted       = 1'b0;

        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_head_ok) begin
                        // Halt wins over the store flag: never issued to memory.
                        if (head_halt) begin
                            commit    = 1'b1;
                            w_state_n = HALTED;
                        end else if (head_wr_mem) begin
                            w_latch   = 1'b1;
                            w_state_n = ST_WAIT;
                        end else begin
                            commit       = 1'b1;
                            // x0 is hardwired; neither write it nor release it.
                            rf_wr_en     = (head_dest_reg != 5'd0);
                            rf_wr_idx    = head_dest_reg;
                            rf_wr_data   = head_value;
                            mt_clear_en  = (head_dest_reg != 5'd0);
                            mt_clear_reg = head_dest_reg;
                            mt_clear_tag = head_tag;
                        end
                    end
                end
                ST_WAIT: begin
                    // Head inputs are ignored here; the request comes from
                    // the latches so it stays stable until acknowledged.
                    mem_req  = 1'b1;
                    mem_addr = r_st_addr;
                    mem_data = r_st_data;
                    if (mem_ack) begin
                        commit       = 1'b1;
                        w_store_done = 1'b1;
                        w_state_n    = IDLE;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, store latches and retirement counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_st_addr <= '0;
            r_st_data <= '0;
            r_retired <= '0;
            r_stores  <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_latch) begin
                r_st_addr <= head_addr;
                r_st_data <= head_value;
            end
            if (commit) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_store_done) begin
                r_stores <= r_stores + 1'b1;
            end
        end
    end

    assign retired_count = r_retired;
    assign store_count   = r_stores;

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
// ============================================================================
// Module   : tb_commit_unit
// Purpose  : Self-checking bench for commit_unit. A behavioural model tracks
//            "halted", "store outstanding" and the retirement counts; a
//            negedge process compares every DUT output against it. Directed
//            scenarios plus randomized traffic, with literal checks pinning
//            the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_unit;

    localparam int XLEN = 32;
    localparam int TAGW = 4;
    localparam int CW   = 4;   // narrow counters so random traffic wraps them

    logic            clock;
    logic            reset;
    logic            head_valid, head_ready, head_wr_mem, head_halt;
    logic [4:0]      head_dest_reg;
    logic [XLEN-1:0] head_value, head_addr;
    logic [TAGW-1:0] head_tag;
    logic            mem_ack;
    logic            commit, rf_wr_en, mt_clear_en, mem_req, halted;
    logic [4:0]      rf_wr_idx, mt_clear_reg;
    logic [XLEN-1:0] rf_wr_data, mem_addr, mem_data;
    logic [TAGW-1:0] mt_clear_tag;
    logic [CW-1:0]   retired_count, store_count;

    commit_unit #(.XLEN(XLEN), .ROB_TAG_LEN(TAGW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_ready(head_ready),
        .head_wr_mem(head_wr_mem), .head_halt(head_halt),
        .head_dest_reg(head_dest_reg), .head_value(head_value),
        .head_addr(head_addr), .head_tag(head_tag), .mem_ack(mem_ack),
        .commit(commit), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data), .mt_clear_en(mt_clear_en),
        .mt_clear_reg(mt_clear_reg), .mt_clear_tag(mt_clear_tag),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .halted(halted), .retired_count(retired_count),
        .store_count(store_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what has architecturally happened so far.
    // ------------------------------------------------------------------
    bit              m_init = 0;   // a reset edge has been seen
    bit              m_halted;
    bit              m_pend;       // a store is waiting for memory
    logic [XLEN-1:0] m_addr, m_data;
    int unsigned     m_ret, m_st;  // unbounded counts, wrapped on compare

    always @(posedge clock) begin
        if (reset) begin
            m_init = 1; m_halted = 0; m_pend = 0;
            m_addr = '0; m_data = '0; m_ret = 0; m_st = 0;
        end else if (m_halted) begin
            // nothing retires any more
        end else if (m_pend) begin
            if (mem_ack) begin
                m_pend = 0; m_ret++; m_st++;
            end
        end else if (head_valid && head_ready) begin
            if (head_halt) begin
                m_halted = 1; m_ret++;
            end else if (head_wr_mem) begin
                m_pend = 1; m_addr = head_addr; m_data = head_value;
            end else begin
                m_ret++;
            end
        end
    end

    // Single compare process: inputs are stable at the negedge.
    always @(negedge clock) begin
        logic e_commit, e_rf, e_req, e_halt;
        logic alu_ret;
        e_commit = 0; e_rf = 0; e_req = 0; e_halt = 0; alu_ret = 0;
        if (!reset) begin
            if (m_halted) begin
                e_halt = 1;
            end else if (m_pend) begin
                e_req    = 1;
                e_commit = mem_ack;
            end else if (head_valid && head_ready) begin
                if (head_halt)        e_commit = 1;
                else if (!head_wr_mem) begin
                    e_commit = 1;
                    alu_ret  = 1;
                    e_rf     = (head_dest_reg != 0);
                end
            end
        end
        chk("commit", commit, e_commit);
        chk("rf_wr_en", rf_wr_en, e_rf);
        chk("mt_clear_en", mt_clear_en, e_rf);
        chk("mem_req", mem_req, e_req);
        chk("halted", halted, e_halt);
        if (e_rf) begin
            chk("rf_wr_idx", rf_wr_idx, head_dest_reg);
            chk("rf_wr_data", rf_wr_data, head_value);
            chk("mt_clear_reg", mt_clear_reg, head_dest_reg);
            chk("mt_clear_tag", mt_clear_tag, head_tag);
        end
        if (e_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_data", mem_data, m_data);
        end
        if (m_init) begin
            chk("retired_count", retired_count, m_ret % (1 << CW));
            chk("store_count", store_count, m_st % (1 << CW));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after each posedge.
    // ------------------------------------------------------------------
    task automatic set_head(input logic v, input logic r, input logic w, input logic h,
                            input logic [4:0] d, input logic [XLEN-1:0] val,
                            input logic [XLEN-1:0] a, input logic [TAGW-1:0] t,
                            input logic ack);
        head_valid = v; head_ready = r; head_wr_mem = w; head_halt = h;
        head_dest_reg = d; head_value = val; head_addr = a; head_tag = t;
        mem_ack = ack;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_step();
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        reset = 1;
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("reset_retired", retired_count, 0);
        chk("reset_stores", store_count, 0);
        reset = 0;

        // ALU retire
        set_head(1, 1, 0, 0, 5'd3, 32'd5, 32'h0, 4'd0, 0);
        #1;
        chk("alu_commit_lit", commit, 1);
        chk("alu_idx_lit", rf_wr_idx, 3);
        chk("alu_data_lit", rf_wr_data, 5);
        tick();
        chk("alu_retired_lit", retired_count, 1);

        // x0 destination
        set_head(1, 1, 0, 0, 5'd0, 32'd7, 32'h0, 4'd2, 0);
        #1;
        chk("x0_rf_lit", rf_wr_en, 0);
        tick();
        chk("x0_retired_lit", retired_count, 2);

        // Store handshake, ack held low 3 cycles
        set_head(1, 1, 1, 0, 5'd4, 32'hAB, 32'h100, 4'd3, 0);
        #1;
        chk("st_head_commit_lit", commit, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_head(1, 1, 0, 0, 5'(i+1), $urandom, $urandom, 4'(i), 0);
            #1;
            chk("st_req_lit", mem_req, 1);
            chk("st_addr_lit", mem_addr, 32'h100);
            chk("st_data_lit", mem_data, 32'hAB);
            tick();
        end
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("st_count_lit", store_count, 1);
        chk("st_retired_lit", retired_count, 3);
        idle_step();

        // Not-ready head for 5 cycles
        for (int i = 0; i < 5; i++) begin
            set_head(1, 0, 0, 0, 5'd9, 32'h55, 0, 4'd5, 0);
            tick();
        end
        set_head(1, 1, 0, 0, 5'd9, 32'h55, 0, 4'd5, 0);
        tick();
        chk("nr_retired_lit", retired_count, 4);
        idle_step();

        // Reset in the second ST_WAIT cycle
        set_head(1, 1, 1, 0, 5'd1, 32'h77, 32'h200, 4'd6, 0);
        tick();
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1;
        set_head(1, 1, 0, 0, 5'd2, 32'h1, 0, 0, 1);
        #1;
        chk("rst_req_lit", mem_req, 0);
        chk("rst_commit_lit", commit, 0);
        tick();
        reset = 0;
        chk("rst_cnt_lit", retired_count, 0);
        set_head(1, 1, 0, 0, 5'd6, 32'h66, 0, 4'd1, 0);
        tick();
        chk("rst_after_lit", retired_count, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_head($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                     5'($urandom), $urandom, $urandom, 4'($urandom),
                     1'($urandom));
            tick();
        end

        // Halt sequence
        reset = 1;
        idle_step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            set_head(1, 1, 0, 0, 5'(i+10), 32'(i), 0, 4'(i), 0);
            tick();
        end
        set_head(1, 1, 1, 1, 5'd0, 0, 0, 4'd7, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_head(1, 1, 0, 0, 5'd12, 32'h9, 0, 4'd8, 1);
            tick();
        end
        chk("halt_flag_lit", halted, 1);
        chk("halt_retired_lit", retired_count, 4);
        chk("halt_stores_lit", store_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the ROB; consumes the ROB head entry every cycle.
- Retires non-store instructions in the cycle they are valid and ready. Writes the register file and releases map-table entries. Pulses `commit` so the ROB advances its head at the next posedge.
- Drives stores to the data-memory port through a req/ack handshake.
- Retires a halt instruction and then stops all further retirement.

Parameters:
- `CNT_WIDTH`, 32, width of the retired-instruction and retired-store counters (wrap modulo 2^CNT_WIDTH).

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `head_valid`  in  1  ROB head slot occupied.
- `head_ready`  in  1  head result/store data available.
- `head_wr_mem`  in  1  head is a store.
- `head_halt`  in  1  head is a halt instruction.
- `head_dest_reg`  in  5  architectural destination of head.
- `head_value`  in  `XLEN`  result (non-store) or store data.
- `head_addr`  in  `XLEN`  store address (don't-care for non-stores).
- `head_tag`  in  `ROB_TAG_LEN`  ROB tag of head.
- `mem_ack`  in  1  memory accepted/completed the store this cycle.
- `commit`  out  1  head retires this cycle; ROB advances head at next posedge.
- `rf_wr_en`  out  1  register-file write enable.
- `rf_wr_idx`  out  5  register-file write index.
- `rf_wr_data`  out  `XLEN`  register-file write data.
- `mt_clear_en`  out  1  release the map-table entry if it still holds `mt_clear_tag`.
- `mt_clear_reg`  out  5  register to release.
- `mt_clear_tag`  out  `ROB_TAG_LEN`  tag being retired.
- `mem_req`  out  1  store request, held until ack.
- `mem_addr`  out  `XLEN`  store address (from latch).
- `mem_data`  out  `XLEN`  store data (from latch).
- `halted`  out  1  halt has retired.
- `retired_count`  out  `CNT_WIDTH`  instructions retired since reset.
- `store_count`  out  `CNT_WIDTH`  stores retired since reset.

Behaviour:
- FSM states: `IDLE`, `ST_WAIT`, `HALTED`. On reset: state `IDLE`, both counters 0, store latches 0, `halted`=0. All combinational outputs are 0 while reset is high.
- Define `head_ok = head_valid & head_ready`.
- IDLE with `head_ok` and neither `head_wr_mem` nor `head_halt`:
  - `commit`=1 in the same cycle (zero added latency).
  - `rf_wr_en = (head_dest_reg != 0)`, with `rf_wr_idx = head_dest_reg` and `rf_wr_data = head_value`.
  - `mt_clear_en` has the same condition, with `mt_clear_reg = head_dest_reg` and `mt_clear_tag = head_tag`.
  - `retired_count` +1 at posedge. State stays `IDLE`, so back-to-back retirement is one per cycle.
- IDLE with `head_ok` and `head_wr_mem`:
  - `commit`=0.
  - Latch `head_addr` and `head_value` at posedge, then go to `ST_WAIT`.
- ST_WAIT:
  - `mem_req`=1, with `mem_addr`/`mem_data` from the latches, stable until ack.
  - Head inputs are ignored.
  - On `mem_ack`: `commit`=1 in the same cycle, no rf/mt activity, `retired_count`+1, `store_count`+1, next state `IDLE`.
  - Without `mem_ack`: stay in `ST_WAIT`.
  - Minimum store retirement: head ready in cycle N, `mem_req` in N+1, commit in N+1 if acked there.
- IDLE with `head_ok` and `head_halt`:
  - `commit`=1 in the same cycle, no rf/mt write.
  - `retired_count`+1, next state `HALTED`.
- HALTED: `halted`=1; `commit`, `rf_wr_en`, `mt_clear_en`, `mem_req` are all 0 regardless of inputs. Only reset exits.
- `head_valid`=1 with `head_ready`=0: all outputs 0; wait indefinitely.
- `head_valid`=0: `head_ready` and other head fields are ignored.
- `mem_ack` outside `ST_WAIT` is ignored.
- Reset asserted in `ST_WAIT`: `mem_req` drops in the reset cycle, state returns to `IDLE`, no commit, counters 0.
- Counters wrap silently at 2^CNT_WIDTH.
- Precedence when multiple head flags are set: `head_halt` has priority over `head_wr_mem`. A halt is never treated as a store.

Test Plan:
- ALU retire: head {valid=1, ready=1, wr_mem=0, dest=3, value=5, tag=0} in one cycle -> same cycle `commit`=1, `rf_wr_en`=1 idx 3 data 5, `mt_clear` reg 3 tag 0; `retired_count`=1 next cycle.
- x0 destination: head dest=0, value=7 -> `commit`=1, `rf_wr_en`=0, `mt_clear_en`=0, `retired_count` increments.
- Store handshake: store head addr=0x100, data=0xAB; `mem_ack` held low 3 cycles, then high.
  - `commit`=0 in the head cycle.
  - `mem_req`=1 with addr 0x100 / data 0xAB for 4 cycles; `commit`=1 only in the ack cycle.
  - `store_count`=1 afterwards; no `rf_wr_en` throughout.
- Not-ready head: valid=1, ready=0 for 5 cycles, then ready=1 -> `commit` stays 0 for 5 cycles, then 1 exactly once.
- Halt: three back-to-back ALU heads, then a halt head, then another valid ready ALU head.
  - Commit on 4 consecutive cycles, then `halted`=1.
  - No further commits; `retired_count`=4.
- Reset mid-store: reset asserted in the 2nd `ST_WAIT` cycle -> `mem_req`=0 and all other outputs 0 during reset; state `IDLE`, counters 0 after reset; a later ALU head retires normally.
